// File: rtl/lsu_mem_if_pkg.sv
// Shared types and helpers for the load/store front end.
//   state_e  : FSM encoding (idle, bus issue, read wait, response).
//   F3_*     : RV32 load/store width/sign codes.
//   is_legal : checks width code and alignment of one request.
package lsu_mem_if_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; halves need even, words need 4-byte alignment.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = !we;
            F3_HU:   ok = !we && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Bundle of the core request/response handshake and the data-memory bus.
//   slave  : view of the LSU (takes requests, drives the memory bus).
//   master : view of the environment (core + memory).
//   Core side  : req_valid/ready/we/funct3/addr/wdata, resp_valid/rdata/err.
//   Memory side: mem_address/data_in/rd_wr_en/bus_cs/mask, mem_data_out/valid.
interface lsu_mem_if_if #(
    parameter int unsigned AW = 32
) ();

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_in;
    logic          mem_rd_wr_en;
    logic          mem_bus_cs;
    logic [3:0]    mem_mask;
    logic [31:0]   mem_data_out;
    logic          mem_valid;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_data_out, mem_valid,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_data_in, mem_rd_wr_en, mem_bus_cs, mem_mask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_data_out, mem_valid,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_data_in, mem_rd_wr_en, mem_bus_cs, mem_mask
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the byte/half selected by the low
// address bits from the memory word and sign- or zero-extends it.
//   word    : raw 32-bit memory word
//   funct3  : width/sign code
//   addr_lo : byte offset within the word
//   rdata   : extended result
module lsu_load_align
    import lsu_mem_if_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store front end for a word-addressed data memory.
// Accepts one request in idle, rejects illegal ones with an error response,
// otherwise selects the memory for exactly one cycle. Stores respond the
// cycle after issue; loads wait for mem_valid (bounded by TIMEOUT cycles).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave view of lsu_mem_if_if (core handshake + memory bus)
// All outputs come straight from registers.
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_mem_if_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          state_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;
    logic [AW-1:0]   mem_address_q;
    logic [31:0]     mem_data_in_q;
    logic            mem_rd_wr_en_q;
    logic            mem_bus_cs_q;
    logic [3:0]      mem_mask_q;
    logic [CntW-1:0] cnt_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;

    logic [AW-1:0]   req_addr;
    logic [3:0]      mask_d;
    logic [31:0]     data_d;
    logic [31:0]     load_data;

    assign req_addr = bus.req_addr;

    // Lane enables and replicated write data for the request at the port.
    always_comb begin
        mask_d = 4'b0000;
        data_d = bus.req_wdata;
        if (bus.req_we) begin
            case (bus.req_funct3)
                F3_B: begin
                    mask_d = 4'b0001 << req_addr[1:0];
                    data_d = {4{bus.req_wdata[7:0]}};
                end
                F3_H: begin
                    mask_d = req_addr[1] ? 4'b1100 : 4'b0011;
                    data_d = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    mask_d = 4'b1111;
                    data_d = bus.req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .word    (bus.mem_data_out),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0;
            resp_err_q     <= 1'b0;
            mem_address_q  <= '0;
            mem_data_in_q  <= 32'h0;
            mem_rd_wr_en_q <= 1'b0;
            mem_bus_cs_q   <= 1'b0;
            mem_mask_q     <= 4'b0000;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        addr_lo_q   <= req_addr[1:0];
                        req_ready_q <= 1'b0;
                        if (is_legal(bus.req_we, bus.req_funct3, req_addr[1:0])) begin
                            state_q        <= StIssue;
                            mem_bus_cs_q   <= 1'b1;
                            mem_rd_wr_en_q <= bus.req_we;
                            mem_mask_q     <= mask_d;
                            mem_address_q  <= req_addr;
                            mem_data_in_q  <= data_d;
                        end else begin
                            // Rejected without touching the bus.
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end
                    end
                end
                StIssue: begin
                    mem_bus_cs_q   <= 1'b0;
                    mem_rd_wr_en_q <= 1'b0;
                    mem_mask_q     <= 4'b0000;
                    cnt_q          <= '0;
                    if (we_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.mem_valid) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end else if (cnt_q == CntMax) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_data_in  = mem_data_in_q;
    assign bus.mem_rd_wr_en = mem_rd_wr_en_q;
    assign bus.mem_bus_cs   = mem_bus_cs_q;
    assign bus.mem_mask     = mem_mask_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a small word memory model
// (writes on negedge, registered reads with a one-cycle mem_valid).
module tb_lsu_mem_if;

    logic clk;
    logic rst_n;
    logic suppress;
    logic stray;
    int   errors;
    int   checks;

    logic [31:0] mem [16];

    lsu_mem_if_if #(.AW(32)) bus ();

    lsu_mem_if #(
        .TIMEOUT (16),
        .AW      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model.
    always @(negedge clk) begin
        if (bus.mem_bus_cs && bus.mem_rd_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_mask[i]) mem[bus.mem_address[5:2]][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mem_bus_cs && !bus.mem_rd_wr_en && !suppress) begin
            bus.mem_data_out <= mem[bus.mem_address[5:2]];
            bus.mem_valid    <= 1'b1;
        end else begin
            bus.mem_valid <= stray;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request from a negedge in idle; checks bus state in the cycle
    // after acceptance, response latency (cycles after acceptance), data and error.
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic exp_cs, input logic [3:0] exp_mask,
                       input logic [31:0] exp_din);
        int n;
        int lat;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, "_cs"}, 32'(bus.mem_bus_cs), 32'(exp_cs));
        if (exp_cs) begin
            check({tag, "_we"}, 32'(bus.mem_rd_wr_en), 32'(we));
            check({tag, "_mask"}, 32'(bus.mem_mask), 32'(exp_mask));
            check({tag, "_addr"}, bus.mem_address, addr);
            if (we) check({tag, "_din"}, bus.mem_data_in, exp_din);
        end
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, "_rdy_resp"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int pulses;
        errors = 0;
        checks = 0;
        suppress = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_data_out = 32'h0;
        bus.mem_valid    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_cs", 32'(bus.mem_bus_cs), 32'd0);
        check("rst_we", 32'(bus.mem_rd_wr_en), 32'd0);
        check("rst_mask", 32'(bus.mem_mask), 32'd0);
        check("rst_addr", bus.mem_address, 32'h0);
        check("rst_din", bus.mem_data_in, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        //  tag      we  f3      addr   wdata         lat rdata         err cs mask     din
        run("sw10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0,         0, 1, 4'b1111, 32'hDEADBEEF);
        run("lw10",  0, 3'b010, 32'h10, 32'h0,        3, 32'hDEADBEEF, 0, 1, 4'b0000, 32'h0);
        run("sb13",  1, 3'b000, 32'h13, 32'h12345680, 2, 32'h0,         0, 1, 4'b1000, 32'h80808080);
        run("lb13",  0, 3'b000, 32'h13, 32'h0,        3, 32'hFFFFFF80, 0, 1, 4'b0000, 32'h0);
        run("lbu13", 0, 3'b100, 32'h13, 32'h0,        3, 32'h00000080, 0, 1, 4'b0000, 32'h0);
        run("lh12",  0, 3'b001, 32'h12, 32'h0,        3, 32'hFFFF80AD, 0, 1, 4'b0000, 32'h0);
        run("lhu12", 0, 3'b101, 32'h12, 32'h0,        3, 32'h000080AD, 0, 1, 4'b0000, 32'h0);
        run("sw20",  1, 3'b010, 32'h20, 32'h0,        2, 32'h0,         0, 1, 4'b1111, 32'h0);
        run("sh22",  1, 3'b001, 32'h22, 32'hFFFF1234, 2, 32'h0,         0, 1, 4'b1100, 32'h12341234);
        run("lh22",  0, 3'b001, 32'h22, 32'h0,        3, 32'h00001234, 0, 1, 4'b0000, 32'h0);
        run("lw20",  0, 3'b010, 32'h20, 32'h0,        3, 32'h12340000, 0, 1, 4'b0000, 32'h0);

        // Illegal requests: error response one cycle after acceptance, no bus select.
        run("lw21",  0, 3'b010, 32'h21, 32'h0,        1, 32'h0,         1, 0, 4'b0000, 32'h0);
        run("sh03",  1, 3'b001, 32'h03, 32'h5555,     1, 32'h0,         1, 0, 4'b0000, 32'h0);
        run("f3_011",0, 3'b011, 32'h20, 32'h0,        1, 32'h0,         1, 0, 4'b0000, 32'h0);
        run("sbu",   1, 3'b100, 32'h20, 32'h0,        1, 32'h0,         1, 0, 4'b0000, 32'h0);

        // Timeout: 16 wait cycles, then an error.
        suppress = 1'b1;
        run("lw_to", 0, 3'b010, 32'h10, 32'h0,       18, 32'h0,         1, 1, 4'b0000, 32'h0);
        suppress = 1'b0;
        run("lw_ok", 0, 3'b010, 32'h20, 32'h0,        3, 32'h12340000, 0, 1, 4'b0000, 32'h0);

        // Reset while waiting on the memory.
        suppress = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_cs", 32'(bus.mem_bus_cs), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        suppress = 1'b0;
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        check("mid_cs_off", 32'(bus.mem_bus_cs), 32'd0);
        pulses = 0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_seen", 32'(bus.mem_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid) pulses++;
            if (i < 7) @(negedge clk);
        end
        check("mid_no_resp", 32'(pulses), 32'd0);
        check("mid_ready_hold", 32'(bus.req_ready), 32'd1);
        run("lw_after", 0, 3'b010, 32'h10, 32'h0,     3, 32'h80ADBEEF, 0, 1, 4'b0000, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
